// File: rtl/acc_stim_driver.sv
// Stimulus source and scoreboard for the 4-bit dual-register accumulator:
// resets it, drives `add` per mode, and checks z1..z4 against a shadow x/y model.
module acc_stim_driver #(
  parameter int WIDTH     = 4,
  parameter int TARGET    = 10,
  parameter int MAX_STEPS = 15,
  parameter int STEP_W    = 5
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_start,
  input  logic [1:0]        i_mode,
  input  logic              i_z1,
  input  logic              i_z2,
  input  logic              i_z3,
  input  logic              i_z4,
  output logic              o_acc_reset_n,
  output logic [WIDTH-1:0]  o_add,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_hit,
  output logic              o_error,
  output logic [STEP_W-1:0] o_step_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_INIT, S_DRIVE, S_DONE} state_t;

  localparam logic [WIDTH-1:0]  TGT  = WIDTH'(TARGET);
  localparam logic [STEP_W-1:0] MAXS = STEP_W'(MAX_STEPS);
  localparam logic [WIDTH-1:0]  ONE  = WIDTH'(1);
  localparam logic [WIDTH-1:0]  TWO  = WIDTH'(2);
  localparam logic [WIDTH-1:0]  FIVE = WIDTH'(5);

  state_t              r_state, w_next;
  logic [1:0]          r_mode;
  logic [WIDTH-1:0]    r_x, r_y;
  logic                r_tog;
  logic                r_hit, r_err;
  logic [STEP_W-1:0]   r_step;

  logic [3:0]          w_exp_z;
  logic                w_mismatch;
  logic [WIDTH-1:0]    w_mode_add;
  logic                w_apply, w_clear, w_load, w_set_hit, w_set_err;

  // Expected flags are pure functions of the shadow registers, compared in the same cycle.
  assign w_exp_z    = {r_x >= TGT, !(r_x <= TGT), r_x > TGT, (r_x == TGT) || (r_y == TGT)};
  assign w_mismatch = ({i_z1, i_z2, i_z3, i_z4} != w_exp_z);

  always_comb begin
    w_mode_add = '0;
    case (r_mode)
      2'd0: w_mode_add = ONE;
      2'd1: w_mode_add = TWO;
      2'd2: w_mode_add = r_tog ? TWO : ONE;
      default: w_mode_add = '0;
    endcase
  end

  always_comb begin
    w_next    = r_state;
    w_apply   = 1'b0;
    w_clear   = 1'b0;
    w_load    = 1'b0;
    w_set_hit = 1'b0;
    w_set_err = 1'b0;
    case (r_state)
      S_IDLE: if (i_start) begin
        w_clear = 1'b1;
        w_next  = S_INIT;
      end
      S_INIT: begin
        w_load = 1'b1;
        w_next = S_DRIVE;
      end
      S_DRIVE: begin
        if (w_mismatch) begin
          w_set_err = 1'b1;
          w_next    = S_DONE;
        end else if (r_x >= TGT) begin
          w_set_hit = 1'b1;
          w_next    = S_DONE;
        end else if (r_step == MAXS) begin
          w_next = S_DONE;
        end else begin
          w_apply = 1'b1;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // add is zero in every non-applying cycle so the accumulator stays frozen.
  assign o_add         = w_apply ? w_mode_add : '0;
  assign o_acc_reset_n = (r_state != S_INIT);
  assign o_busy        = (r_state == S_INIT) || (r_state == S_DRIVE);
  assign o_done        = (r_state == S_DONE);
  assign o_hit         = r_hit;
  assign o_error       = r_err;
  assign o_step_cnt    = r_step;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= S_IDLE;
      r_mode  <= 2'd0;
      r_x     <= '0;
      r_y     <= '0;
      r_tog   <= 1'b0;
      r_hit   <= 1'b0;
      r_err   <= 1'b0;
      r_step  <= '0;
    end else begin
      r_state <= w_next;
      if (w_clear) begin
        r_mode <= i_mode;
        r_hit  <= 1'b0;
        r_err  <= 1'b0;
        r_step <= '0;
      end
      if (w_load) begin
        r_x   <= ONE;
        r_y   <= ONE;
        r_tog <= 1'b0;
      end
      if (w_set_hit) r_hit <= 1'b1;
      if (w_set_err) r_err <= 1'b1;
      if (w_apply) begin
        r_step <= r_step + 1'b1;
        r_tog  <= ~r_tog;
        if (w_mode_add < TWO) begin
          r_x <= r_x + w_mode_add;
          r_y <= r_y + w_mode_add;
        end else begin
          if (r_x < FIVE) r_x <= r_x + r_y;
          r_y <= r_x;
        end
      end
    end
  end

endmodule

// File: tb/tb_acc_stim_driver.sv
// Bench for acc_stim_driver: a behavioural accumulator answers the driver, and
// each run's outcome is checked against hand-computed vectors.
module tb_acc_stim_driver;

  logic       clk = 1'b0;
  logic       reset, start;
  logic [1:0] mode;
  logic       z1, z2, z3, z4;
  logic       acc_reset_n, busy, done, hit, error;
  logic [3:0] add;
  logic [4:0] step_cnt;

  logic [3:0] ax = 4'd0, ay = 4'd0;
  logic       inj = 1'b0;

  int n_chk = 0, n_err = 0;

  always #5 clk = ~clk;

  acc_stim_driver dut (
    .i_clk(clk), .i_reset(reset), .i_start(start), .i_mode(mode),
    .i_z1(z1), .i_z2(z2), .i_z3(z3), .i_z4(z4),
    .o_acc_reset_n(acc_reset_n), .o_add(add), .o_busy(busy), .o_done(done),
    .o_hit(hit), .o_error(error), .o_step_cnt(step_cnt)
  );

  // Accumulator under drive: sync active-low reset loads 1/1.
  always @(posedge clk) begin
    if (!acc_reset_n) begin
      ax <= 4'd1;
      ay <= 4'd1;
    end else if (add < 4'd2) begin
      ax <= ax + add;
      ay <= ay + add;
    end else begin
      if (ax < 4'd5) ax <= ax + ay;
      ay <= ax;
    end
  end

  assign z1 = (ax >= 4'd10);
  assign z2 = !(ax <= 4'd10);
  assign z3 = (ax > 4'd10) || (inj && ax == 4'd3);
  assign z4 = (ax == 4'd10) || (ay == 4'd10);

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic start_run(input logic [1:0] m);
    @(negedge clk); start = 1'b1; mode = m;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic wait_done(output bit ok, output int rstlow);
    ok = 1'b0; rstlow = 0;
    for (int c = 0; c < 100; c++) begin
      if (!acc_reset_n) rstlow++;
      if (done) begin ok = 1'b1; break; end
      @(negedge clk);
    end
  endtask

  typedef struct {
    logic [1:0] mode;
    logic       inj;
    int         hit;
    int         err;
    int         steps;
    int         fx;
  } vec_t;

  vec_t v[5];

  initial begin
    bit ok;
    int rl, dcnt;

    v[0] = '{mode: 2'd0, inj: 1'b0, hit: 1, err: 0, steps: 9,  fx: 10};
    v[1] = '{mode: 2'd2, inj: 1'b0, hit: 1, err: 0, steps: 13, fx: 10};
    v[2] = '{mode: 2'd1, inj: 1'b0, hit: 0, err: 0, steps: 15, fx: 5};
    v[3] = '{mode: 2'd3, inj: 1'b0, hit: 0, err: 0, steps: 15, fx: 1};
    v[4] = '{mode: 2'd0, inj: 1'b1, hit: 0, err: 1, steps: 2,  fx: 3};

    reset = 1'b1; start = 1'b0; mode = 2'd0;
    #12;
    chk("rst_acc_reset_n", acc_reset_n, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_hit", hit, 0);
    chk("rst_error", error, 0);
    chk("rst_step", step_cnt, 0);
    chk("rst_add", add, 0);
    @(negedge clk); reset = 1'b0;

    foreach (v[i]) begin
      inj = v[i].inj;
      start_run(v[i].mode);
      chk("init_busy", busy, 1);
      wait_done(ok, rl);
      chk("done_seen", ok, 1);
      chk("acc_reset_low_cycles", rl, 1);
      chk("done_hit", hit, v[i].hit);
      chk("done_error", error, v[i].err);
      chk("done_steps", step_cnt, v[i].steps);
      chk("done_busy", busy, 0);
      chk("done_add", add, 0);
      chk("final_x", ax, v[i].fx);
      @(negedge clk);
      chk("idle_done_low", done, 0);
      chk("idle_hold_hit", hit, v[i].hit);
      chk("idle_hold_steps", step_cnt, v[i].steps);
      inj = 1'b0;
    end

    // Reset during DRIVE at step 4: outputs drop asynchronously, no done pulse.
    start_run(2'd0);
    ok = 1'b0;
    for (int c = 0; c < 50; c++) begin
      if (busy && step_cnt == 5'd4) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    chk("reach_step4", ok, 1);
    reset = 1'b1;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_step", step_cnt, 0);
    chk("midrst_add", add, 0);
    chk("midrst_acc_reset_n", acc_reset_n, 1);
    @(negedge clk); reset = 1'b0;
    dcnt = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (done || busy) dcnt++;
    end
    chk("midrst_no_done_or_busy", dcnt, 0);

    // Start pulse during DRIVE with another mode must not disturb the run.
    start_run(2'd0);
    repeat (3) @(negedge clk);
    start = 1'b1; mode = 2'd1;
    @(negedge clk); start = 1'b0;
    wait_done(ok, rl);
    chk("restart_done_seen", ok, 1);
    chk("restart_hit", hit, 1);
    chk("restart_error", error, 0);
    chk("restart_steps", step_cnt, 9);
    chk("restart_final_x", ax, 10);
    @(negedge clk);
    chk("restart_idle", busy, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
